// File: rtl/clause_array_sched.sv
// clause_array_sched
//
// Scheduler for the clause array's terminal cells. It waits a fixed settle
// time after a start or after each accepted implication, then samples the
// array once per round. A conflict on any row wins: the lowest conflicting
// row and its max level are reported until acknowledged. Otherwise one
// implication request is granted round-robin to the BCP core. With no
// requests at all, a one-cycle done pulse ends the round.
//
// Ports:
//   clk             clock
//   rst             synchronous reset, active-low
//   start_i         begin a propagation round (sampled only when idle)
//   imp_drv_i       per-row implication request
//   cclause_drv_i   per-row conflict flag
//   max_lvl_i       per-row max level, row k at [k*WIDTH_LVL +: WIDTH_LVL]
//   imp_valid_o     implication grant valid
//   imp_grant_o     one-hot granted row, zero when not valid
//   imp_ready_i     BCP core accepts the granted implication
//   conflict_o      conflict reported, held until acknowledged
//   conflict_idx_o  index of the conflicting row
//   conflict_lvl_o  max level of the conflicting row
//   conflict_ack_i  conflict consumed
//   done_o          one-cycle pulse: round ended with nothing to report
//   busy_o          scheduler is not idle
module clause_array_sched #(
    parameter int NUM_CLAUSES   = 8,
    parameter int WIDTH_LVL     = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int IDX_W         = $clog2(NUM_CLAUSES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [NUM_CLAUSES-1:0]         imp_drv_i,
    input  logic [NUM_CLAUSES-1:0]         cclause_drv_i,
    input  logic [NUM_CLAUSES*WIDTH_LVL-1:0] max_lvl_i,
    output logic                           imp_valid_o,
    output logic [NUM_CLAUSES-1:0]         imp_grant_o,
    input  logic                           imp_ready_i,
    output logic                           conflict_o,
    output logic [IDX_W-1:0]               conflict_idx_o,
    output logic [WIDTH_LVL-1:0]           conflict_lvl_o,
    input  logic                           conflict_ack_i,
    output logic                           done_o,
    output logic                           busy_o
);

    // The counter only ever holds values up to SETTLE_CYCLES-1.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]       CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]       PTR_RESET = IDX_W'(NUM_CLAUSES - 1);
    localparam logic [NUM_CLAUSES-1:0] ONE_HOT0  = NUM_CLAUSES'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ARB,
        ST_IMP,
        ST_CONFL,
        ST_DONE
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [IDX_W-1:0]         ptr_q;
    logic [IDX_W-1:0]         grant_idx_q;
    logic [NUM_CLAUSES-1:0]   grant_q;
    logic [IDX_W-1:0]         conf_idx_q;
    logic [WIDTH_LVL-1:0]     conf_lvl_q;

    logic                     conf_found;
    logic [IDX_W-1:0]         conf_idx;
    logic [WIDTH_LVL-1:0]     conf_lvl;
    logic                     imp_found;
    logic [IDX_W-1:0]         imp_idx;
    logic [IDX_W-1:0]         cand;

    // Lowest-index conflict: scanning downwards lets the lowest set row
    // overwrite any higher one.
    always_comb begin
        conf_found = 1'b0;
        conf_idx   = '0;
        conf_lvl   = '0;
        for (int i = NUM_CLAUSES - 1; i >= 0; i--) begin
            if (cclause_drv_i[i]) begin
                conf_found = 1'b1;
                conf_idx   = IDX_W'(i);
                conf_lvl   = max_lvl_i[i*WIDTH_LVL +: WIDTH_LVL];
            end
        end
    end

    // Round-robin search starting at ptr+1. Offsets are scanned from the
    // farthest (ptr itself, offset NUM_CLAUSES) to the nearest so that the
    // first request after ptr wins; ptr is only granted again when it is
    // the sole requester.
    always_comb begin
        imp_found = 1'b0;
        imp_idx   = '0;
        cand      = '0;
        for (int k = NUM_CLAUSES; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_CLAUSES);
            if (imp_drv_i[cand]) begin
                imp_found = 1'b1;
                imp_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (conf_found)     state_d = ST_CONFL;
                else if (imp_found) state_d = ST_IMP;
                else                state_d = ST_DONE;
            end
            ST_IMP: begin
                if (imp_ready_i) state_d = ST_SETTLE;
            end
            ST_CONFL: begin
                if (conflict_ack_i) state_d = ST_IDLE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Settle counter, round-robin pointer and the latched grant/conflict
    // registers. The grant is captured in ARB so it stays stable through
    // IMP even if the requesting row drops its request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            ptr_q       <= PTR_RESET;
            grant_idx_q <= '0;
            grant_q     <= '0;
            conf_idx_q  <= '0;
            conf_lvl_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) cnt_q <= CNT_LOAD;
                end
                ST_SETTLE: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                ST_ARB: begin
                    if (conf_found) begin
                        conf_idx_q <= conf_idx;
                        conf_lvl_q <= conf_lvl;
                    end else if (imp_found) begin
                        grant_idx_q <= imp_idx;
                        grant_q     <= ONE_HOT0 << imp_idx;
                    end
                end
                ST_IMP: begin
                    if (imp_ready_i) begin
                        ptr_q <= grant_idx_q;
                        cnt_q <= CNT_LOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imp_valid_o    = (state_q == ST_IMP);
    assign imp_grant_o    = (state_q == ST_IMP) ? grant_q : '0;
    assign conflict_o     = (state_q == ST_CONFL);
    assign conflict_idx_o = conf_idx_q;
    assign conflict_lvl_o = conf_lvl_q;
    assign done_o         = (state_q == ST_DONE);
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clause_array_sched.sv
// tb_clause_array_sched
//
// Self-checking bench for clause_array_sched. Expected behaviour comes from
// a round-level reference model: outcome timing follows the fixed settle
// latency, conflicts resolve to the lowest flagged row, and grants follow a
// round-robin pointer kept as a plain integer.
module tb_clause_array_sched;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int S  = 2;
    localparam int IW = 3;

    logic             clk;
    logic             rst;
    logic             start_i;
    logic [N-1:0]     imp_drv_i;
    logic [N-1:0]     cclause_drv_i;
    logic [N*W-1:0]   max_lvl_i;
    logic             imp_valid_o;
    logic [N-1:0]     imp_grant_o;
    logic             imp_ready_i;
    logic             conflict_o;
    logic [IW-1:0]    conflict_idx_o;
    logic [W-1:0]     conflict_lvl_o;
    logic             conflict_ack_i;
    logic             done_o;
    logic             busy_o;

    int               checks = 0;
    int               errors = 0;
    int               mPtr;
    logic [W-1:0]     lvlTab [N];

    clause_array_sched #(
        .NUM_CLAUSES  (N),
        .WIDTH_LVL    (W),
        .SETTLE_CYCLES(S),
        .IDX_W        (IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .imp_drv_i     (imp_drv_i),
        .cclause_drv_i (cclause_drv_i),
        .max_lvl_i     (max_lvl_i),
        .imp_valid_o   (imp_valid_o),
        .imp_grant_o   (imp_grant_o),
        .imp_ready_i   (imp_ready_i),
        .conflict_o    (conflict_o),
        .conflict_idx_o(conflict_idx_o),
        .conflict_lvl_o(conflict_lvl_o),
        .conflict_ack_i(conflict_ack_i),
        .done_o        (done_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] imp, input logic [N-1:0] ccl);
        imp_drv_i     = imp;
        cclause_drv_i = ccl;
        for (int i = 0; i < N; i++) max_lvl_i[i*W +: W] = lvlTab[i];
    endtask

    function automatic int rrPick(input logic [N-1:0] req, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int lowestSet(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic randomizeLevels();
        for (int i = 0; i < N; i++) lvlTab[i] = W'($urandom);
    endtask

    // Drives the controls that the current state must ignore.
    task automatic wiggleIgnored();
        start_i        = 1'($urandom);
        imp_ready_i    = 1'($urandom);
        conflict_ack_i = 1'($urandom);
    endtask

    task automatic quietControls();
        start_i        = 1'b0;
        imp_ready_i    = 1'b0;
        conflict_ack_i = 1'b0;
    endtask

    task automatic checkQuiet(input string tag, input logic expBusy);
        checkOutput({tag, "_valid"}, imp_valid_o, 0);
        checkOutput({tag, "_grant"}, imp_grant_o, 0);
        checkOutput({tag, "_conflict"}, conflict_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_busy"}, busy_o, expBusy);
    endtask

    task automatic checkAllZero(input string tag);
        checkQuiet(tag, 1'b0);
        checkOutput({tag, "_idx"}, conflict_idx_o, 0);
        checkOutput({tag, "_lvl"}, conflict_lvl_o, 0);
    endtask

    // One full round: start, then repeated settle/outcome phases until a
    // conflict is acknowledged or done pulses.
    task automatic runRound(input logic [N-1:0] req0, input logic [N-1:0] ccl0,
                            input int bpMin, input int bpMax, input bit randConf);
        logic [N-1:0] req;
        logic [N-1:0] ccl;
        logic [N-1:0] gbit;
        int           g;
        int           ci;
        int           bp;
        bit           finished;
        req = req0;
        ccl = ccl0;
        finished = 1'b0;
        applyStimulus(req, ccl);
        quietControls();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int iter = 0; iter <= N + 1 && !finished; iter++) begin
            for (int c = 1; c <= S + 1; c++) begin
                wiggleIgnored();
                checkQuiet("settle", 1'b1);
                tick();
            end
            quietControls();
            if (ccl != '0) begin
                ci = lowestSet(ccl);
                checkOutput("confl_flag", conflict_o, 1);
                checkOutput("confl_idx", conflict_idx_o, ci);
                checkOutput("confl_lvl", conflict_lvl_o, lvlTab[ci]);
                checkOutput("confl_valid", imp_valid_o, 0);
                checkOutput("confl_grant", imp_grant_o, 0);
                checkOutput("confl_done", done_o, 0);
                checkOutput("confl_busy", busy_o, 1);
                bp = $urandom_range(bpMax, bpMin);
                for (int b = 0; b < bp; b++) begin
                    start_i       = 1'($urandom);
                    imp_ready_i   = 1'($urandom);
                    cclause_drv_i = N'($urandom);
                    tick();
                    checkOutput("confl_hold", conflict_o, 1);
                    checkOutput("confl_hold_idx", conflict_idx_o, ci);
                    checkOutput("confl_hold_lvl", conflict_lvl_o, lvlTab[ci]);
                end
                quietControls();
                conflict_ack_i = 1'b1;
                tick();
                conflict_ack_i = 1'b0;
                checkOutput("ack_conflict", conflict_o, 0);
                checkOutput("ack_busy", busy_o, 0);
                finished = 1'b1;
            end else if (req != '0) begin
                g    = rrPick(req, mPtr);
                gbit = N'(1) << g;
                checkOutput("imp_valid", imp_valid_o, 1);
                checkOutput("imp_grant", imp_grant_o, gbit);
                checkOutput("imp_conflict", conflict_o, 0);
                checkOutput("imp_done", done_o, 0);
                checkOutput("imp_busy", busy_o, 1);
                bp = $urandom_range(bpMax, bpMin);
                for (int b = 0; b < bp; b++) begin
                    imp_drv_i      = req & ~gbit;
                    start_i        = 1'($urandom);
                    conflict_ack_i = 1'($urandom);
                    tick();
                    checkOutput("bp_valid", imp_valid_o, 1);
                    checkOutput("bp_grant", imp_grant_o, gbit);
                end
                quietControls();
                imp_ready_i = 1'b1;
                tick();
                imp_ready_i = 1'b0;
                mPtr = g;
                req  = req & ~gbit;
                if (randConf && $urandom_range(3, 0) == 0) ccl = N'($urandom);
                applyStimulus(req, ccl);
            end else begin
                checkOutput("done_pulse", done_o, 1);
                checkOutput("done_busy", busy_o, 1);
                checkOutput("done_valid", imp_valid_o, 0);
                checkOutput("done_conflict", conflict_o, 0);
                wiggleIgnored();
                tick();
                quietControls();
                checkOutput("after_done", done_o, 0);
                checkOutput("after_done_busy", busy_o, 0);
                finished = 1'b1;
            end
        end
        checkOutput("round_bounded", finished, 1);
    endtask

    initial begin
        rst = 1'b0;
        quietControls();
        for (int i = 0; i < N; i++) lvlTab[i] = '0;
        applyStimulus('0, '0);
        mPtr = N - 1;
        tick();
        tick();
        rst = 1'b1;
        checkAllZero("reset");

        // Empty round: done in cycle S+2, nothing else.
        runRound('0, '0, 0, 0, 1'b0);
        checkOutput("empty_idx", conflict_idx_o, 0);
        checkOutput("empty_lvl", conflict_lvl_o, 0);

        // Two requests served in round-robin order, then done.
        runRound(8'b0000_0110, '0, 0, 0, 1'b0);

        // Conflict beats implications; row 3 is the lowest flagged row.
        randomizeLevels();
        lvlTab[3] = 16'd7;
        runRound(8'hFF, 8'b0010_1000, 3, 3, 1'b0);

        // Backpressure for 5 cycles with the granted request dropped.
        runRound(8'b0001_0001, '0, 5, 5, 1'b0);

        // Wrap: grant row 7, then {7,0} gives row 0 before row 7.
        runRound(8'h80, '0, 0, 0, 1'b0);
        runRound(8'h81, '0, 0, 0, 1'b0);

        // Reset while in IMP: pointer returns to the top row.
        runRound(8'h10, '0, 0, 0, 1'b0);
        applyStimulus(8'b0010_0001, '0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= S + 1; c++) tick();
        checkOutput("pre_rst_valid", imp_valid_o, 1);
        checkOutput("pre_rst_grant", imp_grant_o, 8'b0010_0000);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkAllZero("rst_imp");
        mPtr = N - 1;
        runRound(8'b0010_0001, '0, 0, 1, 1'b0);

        // Reset while in SETTLE.
        runRound(8'h04, '0, 0, 0, 1'b0);
        applyStimulus(8'b0000_1001, '0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checkOutput("pre_rst_busy", busy_o, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkAllZero("rst_settle");
        mPtr = N - 1;
        runRound(8'b0000_1001, '0, 0, 1, 1'b0);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] rq;
            logic [N-1:0] cc;
            randomizeLevels();
            rq = N'($urandom);
            cc = ($urandom_range(2, 0) == 0) ? N'($urandom) : '0;
            runRound(rq, cc, 0, 3, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
